// File: rtl/prewish_mask_responder_if.sv
// rtl/prewish_mask_responder_if.sv - strobe/data/acknowledge bundle between mentor and responder
interface prewish_mask_responder_if #(
    parameter int MASK_W = 8
);
    logic              STB_I;
    logic [MASK_W-1:0] DAT_I;
    logic              ACK_O;

    modport master (
        output STB_I,
        output DAT_I,
        input  ACK_O
    );

    modport slave (
        input  STB_I,
        input  DAT_I,
        output ACK_O
    );
endinterface

// File: rtl/prewish_mask_responder.sv
// rtl/prewish_mask_responder.sv - captures strobed blink masks and plays them MSB-first on an LED
module prewish_mask_responder #(
    parameter int TICK_DIV_BITS = 3,
    parameter int MASK_W        = 8
) (
    input  logic                      CLK_I,
    input  logic                      RST_I,
    prewish_mask_responder_if.slave   bus,
    output logic                      o_led,
    output logic [7:0]                o_frames,
    output logic                      o_ovr
);
    localparam int IDX_W = (MASK_W > 1) ? $clog2(MASK_W) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(MASK_W - 1);

    typedef enum logic {
        IDLE,
        PLAY
    } state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic [TICK_DIV_BITS-1:0] tick_cnt;
    logic                     tick;
    logic                     stb_prev;
    logic                     cap;
    logic                     ack;
    logic [MASK_W-1:0]        pending;
    logic                     pend_vld;
    logic [MASK_W-1:0]        active;
    logic [IDX_W-1:0]         idx;
    logic                     load;
    logic                     play_tick;

    assign tick      = &tick_cnt;
    assign cap       = bus.STB_I & ~stb_prev;
    assign bus.ACK_O = ack;

    // State register
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state; load means the pending mask is swapped into the active slot this cycle
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        play_tick = 1'b0;
        case (state)
            IDLE: begin
                if (tick && pend_vld) begin
                    load      = 1'b1;
                    state_nxt = PLAY;
                end
            end
            PLAY: begin
                if (tick) begin
                    play_tick = 1'b1;
                    if ((idx == '0) && pend_vld) begin
                        load = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Free-running tick divider; the all-ones count is the tick cycle
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // Rising-edge strobe capture, acknowledge and overrun tracking
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            stb_prev <= 1'b0;
            ack      <= 1'b0;
            pending  <= '0;
            pend_vld <= 1'b0;
            o_ovr    <= 1'b0;
        end else begin
            stb_prev <= bus.STB_I;
            ack      <= cap;
            if (cap) begin
                pending  <= bus.DAT_I;
                pend_vld <= 1'b1;
                if (pend_vld && !load) begin
                    o_ovr <= 1'b1;
                end
            end else if (load) begin
                pend_vld <= 1'b0;
            end
        end
    end

    // Playback: shift out the active mask one bit per tick, count completed frames
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            active   <= '0;
            idx      <= IDX_TOP;
            o_led    <= 1'b0;
            o_frames <= '0;
        end else begin
            if (load) begin
                active <= pending;
            end
            if (state == IDLE && load) begin
                idx <= IDX_TOP;
            end
            if (play_tick) begin
                o_led <= active[idx];
                if (idx == '0) begin
                    idx      <= IDX_TOP;
                    o_frames <= o_frames + 8'd1;
                end else begin
                    idx <= idx - 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_prewish_mask_responder.sv
// tb/tb_prewish_mask_responder.sv - scoreboard bench for prewish_mask_responder
module tb_prewish_mask_responder;
    localparam int TDB = 3;
    localparam int MW  = 8;
    localparam int TP  = 1 << TDB;

    logic       CLK_I;
    logic       RST_I;
    logic       o_led;
    logic [7:0] o_frames;
    logic       o_ovr;

    prewish_mask_responder_if #(.MASK_W(MW)) bus ();

    prewish_mask_responder #(.TICK_DIV_BITS(TDB), .MASK_W(MW)) dut (
        .CLK_I    (CLK_I),
        .RST_I    (RST_I),
        .bus      (bus),
        .o_led    (o_led),
        .o_frames (o_frames),
        .o_ovr    (o_ovr)
    );

    initial CLK_I = 1'b0;
    always #5 CLK_I = ~CLK_I;

    typedef struct {
        int         e;
        logic       led;
        logic [7:0] frames;
        logic       ovr;
    } rec_t;

    rec_t ackq_dummy;
    int   ackq[$];
    rec_t ledq[$];

    int checks = 0;
    int errors = 0;
    int ecount = 0;

    // reference model state: a queue of LED bits left in the frame being shown
    int         since;
    bit         m_play;
    bit         m_pend;
    logic [7:0] m_pmask;
    logic [7:0] m_cur;
    bit         bits[$];
    logic       m_led;
    logic [7:0] m_frames;
    logic       m_ovr;
    logic       m_stb_prev;

    function automatic void model_reset();
        since      = 0;
        m_play     = 0;
        m_pend     = 0;
        m_pmask    = '0;
        m_cur      = '0;
        bits.delete();
        m_led      = 1'b0;
        m_frames   = '0;
        m_ovr      = 1'b0;
        m_stb_prev = 1'b0;
    endfunction

    function automatic void load_bits(logic [7:0] m);
        m_cur = m;
        bits.delete();
        for (int i = 7; i >= 0; i--) bits.push_back(m[i]);
    endfunction

    task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs now applied, then take the edge
    task automatic step();
        bit   cap;
        bit   tk;
        bit   swapped;
        rec_t r;
        if (RST_I) begin
            model_reset();
        end else begin
            since++;
            cap     = bus.STB_I && !m_stb_prev;
            tk      = (since % TP) == 0;
            swapped = 0;
            if (tk) begin
                if (!m_play) begin
                    if (m_pend) begin
                        load_bits(m_pmask);
                        m_pend  = 0;
                        m_play  = 1;
                        swapped = 1;
                    end
                end else begin
                    m_led = bits.pop_front();
                    if (bits.size() == 0) begin
                        m_frames = m_frames + 8'd1;
                        if (m_pend) begin
                            m_cur   = m_pmask;
                            m_pend  = 0;
                            swapped = 1;
                        end
                        load_bits(m_cur);
                    end
                end
            end
            if (cap) begin
                if (m_pend && !swapped) m_ovr = 1'b1;
                m_pmask = bus.DAT_I;
                m_pend  = 1;
                ackq.push_back(ecount + 1);
            end
            if (tk) begin
                r.e      = ecount + 1;
                r.led    = m_led;
                r.frames = m_frames;
                r.ovr    = m_ovr;
                ledq.push_back(r);
            end
            m_stb_prev = bus.STB_I;
        end
        @(posedge CLK_I);
        #1;
        ecount++;
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic strobe(logic [7:0] d, int len);
        bus.STB_I = 1'b1;
        bus.DAT_I = d;
        run(len);
        bus.STB_I = 1'b0;
        bus.DAT_I = $urandom;
    endtask

    task automatic wait_bits(int n);
        int k = 0;
        while (!(m_play && bits.size() == n) && k < 200) begin
            step();
            k++;
        end
        if (k >= 200) begin
            errors++;
            $display("FAIL wait_bits%0d timed out", n);
        end
    endtask

    task automatic wait_boundary();
        int k = 0;
        while (!(m_play && bits.size() == 1 && ((since + 1) % TP) == 0) && k < 200) begin
            step();
            k++;
        end
        if (k >= 200) begin
            errors++;
            $display("FAIL wait_boundary timed out");
        end
    endtask

    task automatic async_reset();
        #2;
        RST_I = 1'b1;
        #1;
        chk("rst_ack", {7'd0, bus.ACK_O}, 8'd0);
        chk("rst_led", {7'd0, o_led}, 8'd0);
        chk("rst_frames", o_frames, 8'd0);
        chk("rst_ovr", {7'd0, o_ovr}, 8'd0);
        model_reset();
        ackq.delete();
        ledq.delete();
        run(2);
        RST_I = 1'b0;
    endtask

    // Monitor: compare acknowledges and per-tick LED/frame/overrun against the scoreboard
    always @(negedge CLK_I) begin
        bit   exp_ack;
        rec_t r;
        exp_ack = (ackq.size() > 0) && (ackq[0] == ecount);
        if (bus.ACK_O || exp_ack) begin
            chk("ack", {7'd0, bus.ACK_O}, {7'd0, exp_ack});
            if (exp_ack) void'(ackq.pop_front());
        end
        if (ackq.size() > 0 && ackq[0] < ecount) begin
            chk("ack_missed", 8'(ackq[0]), 8'(ecount));
            void'(ackq.pop_front());
        end
        if (ledq.size() > 0 && ledq[0].e == ecount) begin
            r = ledq.pop_front();
            chk("tick_led", {7'd0, o_led}, {7'd0, r.led});
            chk("tick_frames", o_frames, r.frames);
            chk("tick_ovr", {7'd0, o_ovr}, {7'd0, r.ovr});
        end
    end

    initial begin
        ackq_dummy = '{e: 0, led: 1'b0, frames: 8'd0, ovr: 1'b0};
        RST_I     = 1'b1;
        bus.STB_I = 1'b0;
        bus.DAT_I = '0;
        model_reset();
        run(3);
        chk("reset_ack", {7'd0, bus.ACK_O}, 8'd0);
        chk("reset_led", {7'd0, o_led}, 8'd0);
        chk("reset_frames", o_frames, 8'd0);
        chk("reset_ovr", {7'd0, o_ovr}, 8'd0);
        RST_I = 1'b0;

        // basic load
        run(1);
        strobe(8'b10100000, 1);
        run(80);
        chk("basic_frames", o_frames, 8'd1);

        // long strobe
        strobe(8'b11001010, 811);
        run(20);
        chk("long_ovr", {7'd0, o_ovr}, 8'd0);

        // frame-boundary swap
        strobe(8'b10000000, 1);
        run(130);
        wait_bits(4);
        strobe(8'b11111111, 1);
        run(200);

        // simultaneous capture and swap
        wait_bits(5);
        strobe(8'hAA, 1);
        wait_boundary();
        strobe(8'h55, 1);
        run(200);
        chk("simul_ovr", {7'd0, o_ovr}, 8'd0);

        // overrun
        wait_bits(7);
        strobe(8'h0F, 1);
        run(3);
        strobe(8'hF0, 1);
        run(150);
        chk("ovr_set", {7'd0, o_ovr}, 8'd1);

        // async reset mid-frame, then idle with no strobe
        wait_bits(5);
        async_reset();
        run(100);

        // strobe held through reset release
        bus.STB_I = 1'b1;
        bus.DAT_I = 8'h3C;
        async_reset();
        run(5);
        bus.STB_I = 1'b0;
        run(100);

        // randomized traffic
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 24) == 0) bus.STB_I = ~bus.STB_I;
            bus.DAT_I = $urandom;
            if (i == 1500) async_reset();
            step();
        end
        bus.STB_I = 1'b0;
        run(3);
        #6;
        chk("final_frames", o_frames, m_frames);
        chk("final_ovr", {7'd0, o_ovr}, {7'd0, m_ovr});
        chk("final_ackq_empty", 8'(ackq.size()), 8'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
